// File: rtl/axil_write_master.sv
// rtl/axil_write_master.sv - AXI4-Lite write master with request FIFO and B-response reporting
// Optional B-response timeout enabled by defining AXIL_WR_TIMEOUT_EN.
module axil_write_master #(
  parameter int WIDTH_ADDR     = 32,
  parameter int WIDTH_DATA     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          write_en,
  input  logic [WIDTH_ADDR-1:0]         write_addr_in,
  input  logic [WIDTH_DATA-1:0]         write_data_in,
  input  logic [WIDTH_DATA/8-1:0]       strobe_in,
  output logic                          write_ready,
  output logic                          write_done,
  output logic [1:0]                    write_resp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [WIDTH_ADDR-1:0]         awaddr,
  output logic [2:0]                    awprot,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [WIDTH_DATA-1:0]         wdata,
  output logic [WIDTH_DATA/8-1:0]       wstrb,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [1:0]                    bresp,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int SW = WIDTH_DATA / 8;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = WIDTH_ADDR + WIDTH_DATA + SW;
  localparam logic [LW-1:0] L_DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [RW-1:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [RW-1:0]         w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;

  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_write_done;
  logic [1:0]            r_write_resp;
  logic [WIDTH_ADDR-1:0] r_awaddr;
  logic [WIDTH_DATA-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_issue_done;
  logic                  w_timeout;
  logic                  w_finish;
  logic                  w_enter_wait;

  assign w_empty     = (r_level == '0);
  assign write_ready = (r_level != L_DEPTH);
  assign fifo_level  = r_level;
  assign w_push      = write_en & write_ready;
  assign w_head      = r_mem[r_rd_ptr];

  // Storage has no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {write_addr_in, write_data_in, strobe_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_aw_hs      = r_awvalid & awready;
  assign w_w_hs       = r_wvalid & wready;
  assign w_b_hs       = bvalid & r_bready;
  assign w_issue_done = (~r_awvalid | awready) & (~r_wvalid | wready);

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state != S_WAIT_RESP) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // A real bvalid in the expiry cycle wins over the forced completion.
  assign w_timeout = (r_state == S_WAIT_RESP) & ~bvalid &
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_issue_done) w_state_nxt = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (w_b_hs | w_timeout) w_state_nxt = w_empty ? S_IDLE : S_ISSUE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_finish     = 1'b0;
    w_enter_wait = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pop = ~w_empty;
      end
      S_ISSUE: begin
        w_enter_wait = w_issue_done;
      end
      S_WAIT_RESP: begin
        w_finish = w_b_hs | w_timeout;
        w_pop    = w_finish & ~w_empty;
      end
      default: begin
        w_pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_write_done <= 1'b0;
      r_write_resp <= 2'b00;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_write_done <= w_finish;
      if (w_pop) begin
        {r_awaddr, r_wdata, r_wstrb} <= w_head;
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end
      if (w_enter_wait) begin
        r_bready <= 1'b1;
      end else if (w_finish) begin
        r_bready <= 1'b0;
      end
      if (w_finish) begin
        r_write_resp <= w_b_hs ? bresp : 2'b10;
      end
    end
  end

  assign awvalid    = r_awvalid;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;
  assign write_done = r_write_done;
  assign write_resp = r_write_resp;
  assign awaddr     = r_awaddr;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign awprot     = 3'b000;

endmodule

// File: tb/tb_axil_write_master.sv
// tb/tb_axil_write_master.sv - randomized bench for axil_write_master against a queue-based model
module tb_axil_write_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int DEPTH = 4;
  localparam int TO = 16;

  logic          clk;
  logic          reset_n;
  logic          write_en;
  logic [AW-1:0] write_addr_in;
  logic [DW-1:0] write_data_in;
  logic [SW-1:0] strobe_in;
  logic          write_ready;
  logic          write_done;
  logic [1:0]    write_resp;
  logic [2:0]    fifo_level;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  axil_write_master #(
    .WIDTH_ADDR(AW), .WIDTH_DATA(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .write_en(write_en), .write_addr_in(write_addr_in),
    .write_data_in(write_data_in), .strobe_in(strobe_in),
    .write_ready(write_ready), .write_done(write_done), .write_resp(write_resp),
    .fifo_level(fifo_level),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;
  int n_done = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: a request queue plus one outstanding write.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } req_t;

  req_t       q[$];
  req_t       cur;
  bit         m_busy, m_aw, m_w, m_b, m_done, m_free, m_push, m_fin;
  logic [1:0] m_resp;
  int         m_sz, m_bcnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      cur = '0;
      m_busy = 0; m_aw = 0; m_w = 0; m_b = 0; m_done = 0;
      m_resp = 2'b00; m_bcnt = 0;
    end else begin
      m_sz   = q.size();
      m_push = write_en && (m_sz != DEPTH);
      m_free = !m_busy;
      m_done = 0;
      if (m_b) begin
        m_fin = bvalid;
`ifdef AXIL_WR_TIMEOUT_EN
        if (!bvalid && m_bcnt == TO - 1) m_fin = 1;
        m_bcnt++;
`endif
        if (m_fin) begin
          m_done = 1;
          m_resp = bvalid ? bresp : 2'b10;
          m_b = 0; m_busy = 0; m_free = 1;
        end
      end else if (m_busy) begin
        if (m_aw && awready) m_aw = 0;
        if (m_w && wready)   m_w  = 0;
        if (!m_aw && !m_w) begin
          m_b = 1;
          m_bcnt = 0;
        end
      end
      if (m_free && m_sz > 0) begin
        cur = q.pop_front();
        m_aw = 1; m_w = 1; m_busy = 1;
      end
      if (m_push) q.push_back('{a: write_addr_in, d: write_data_in, s: strobe_in});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("awvalid", 64'(awvalid), 64'(m_aw));
      chk("wvalid", 64'(wvalid), 64'(m_w));
      chk("bready", 64'(bready), 64'(m_b));
      chk("write_done", 64'(write_done), 64'(m_done));
      chk("fifo_level", 64'(fifo_level), 64'(q.size()));
      chk("write_ready", 64'(write_ready), 64'(q.size() != DEPTH));
      chk("awprot", 64'(awprot), 64'(0));
      if (m_done) chk("write_resp", 64'(write_resp), 64'(m_resp));
      if (m_aw) chk("awaddr", 64'(awaddr), 64'(cur.a));
      if (m_w) begin
        chk("wdata", 64'(wdata), 64'(cur.d));
        chk("wstrb", 64'(wstrb), 64'(cur.s));
      end
    end
    if (write_done) n_done++;
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    @(negedge clk);
    write_en = 1'b1; write_addr_in = a; write_data_in = d; strobe_in = s;
  endtask

  task automatic idle_in;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_awvalid"}, 64'(awvalid), 64'(0));
    chk({tag, "_wvalid"}, 64'(wvalid), 64'(0));
    chk({tag, "_bready"}, 64'(bready), 64'(0));
    chk({tag, "_done"}, 64'(write_done), 64'(0));
    chk({tag, "_resp"}, 64'(write_resp), 64'(0));
    chk({tag, "_level"}, 64'(fifo_level), 64'(0));
    chk({tag, "_ready"}, 64'(write_ready), 64'(1));
    chk({tag, "_awaddr"}, 64'(awaddr), 64'(0));
    chk({tag, "_wdata"}, 64'(wdata), 64'(0));
    chk({tag, "_wstrb"}, 64'(wstrb), 64'(0));
  endtask

  initial begin
    reset_n = 1'b0; write_en = 1'b0; write_addr_in = '0; write_data_in = '0; strobe_in = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // Single write with the minimum latency path.
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    push(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    idle_in();
    chk("single_level", 64'(fifo_level), 64'(1));
    chk("single_aw_early", 64'(awvalid), 64'(0));
    @(negedge clk);
    chk("single_awvalid", 64'(awvalid), 64'(1));
    chk("single_wvalid", 64'(wvalid), 64'(1));
    chk("single_awaddr", 64'(awaddr), 64'h10);
    chk("single_wdata", 64'(wdata), 64'hDEAD_BEEF);
    @(negedge clk);
    chk("single_aw_drop", 64'(awvalid), 64'(0));
    chk("single_bready", 64'(bready), 64'(1));
    @(negedge clk);
    chk("single_done", 64'(write_done), 64'(1));
    chk("single_resp", 64'(write_resp), 64'(0));
    @(negedge clk);
    chk("single_done_pulse", 64'(write_done), 64'(0));

    // FIFO fill with awready held low; the sixth push must be dropped.
    awready = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) push(32'h100 + 32'(i * 4), $urandom, 4'hF);
    idle_in();
    chk("fill_level", 64'(fifo_level), 64'(4));
    chk("fill_ready", 64'(write_ready), 64'(0));
    awready = 1'b1;
    repeat (40) @(negedge clk);
    chk("fill_done_cnt", 64'(n_done), 64'(5));

    // W handshake three cycles ahead of AW.
    awready = 1'b0; wready = 1'b0;
    push(32'h200, 32'h1234_5678, 4'h3);
    idle_in();
    @(negedge clk);
    wready = 1'b1;
    repeat (3) @(negedge clk);
    chk("skew_awvalid", 64'(awvalid), 64'(1));
    chk("skew_wvalid", 64'(wvalid), 64'(0));
    chk("skew_bready", 64'(bready), 64'(0));
    awready = 1'b1;
    @(negedge clk);
    chk("skew_aw_drop", 64'(awvalid), 64'(0));
    chk("skew_bready_up", 64'(bready), 64'(1));
    repeat (4) @(negedge clk);

    // DECERR response followed by a back-to-back issue; second entry has zero strobes.
    bvalid = 1'b0; bresp = 2'b11;
    push(32'h300, 32'hA5A5_A5A5, 4'hF);
    push(32'h304, 32'h5A5A_5A5A, 4'h0);
    push(32'h308, 32'h0F0F_0F0F, 4'h1);
    idle_in();
    bvalid = 1'b1;
    @(negedge clk);
    chk("err_done", 64'(write_done), 64'(1));
    chk("err_resp", 64'(write_resp), 64'(3));
    chk("err_b2b_awvalid", 64'(awvalid), 64'(1));
    chk("err_b2b_awaddr", 64'(awaddr), 64'h304);
    chk("err_zero_strb", 64'(wstrb), 64'(0));
    repeat (10) @(negedge clk);

    // Asynchronous reset while waiting for B with two entries queued.
    bvalid = 1'b0; bresp = 2'b00;
    push(32'h400, 32'h1, 4'hF);
    push(32'h404, 32'h2, 4'hF);
    push(32'h408, 32'h3, 4'hF);
    idle_in();
    chk("mid_level", 64'(fifo_level), 64'(2));
    chk("mid_bready", 64'(bready), 64'(1));
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0;
    bvalid = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_done", 64'(n_done), 64'(0));

    // Randomized traffic with random ready/valid and response codes.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      write_en      = ($urandom_range(0, 1) == 1);
      write_addr_in = $urandom;
      write_data_in = $urandom;
      strobe_in     = 4'($urandom);
      awready       = ($urandom_range(0, 9) < 6);
      wready        = ($urandom_range(0, 9) < 6);
      bvalid        = ($urandom_range(0, 9) < 5);
      bresp         = 2'($urandom);
    end

    @(negedge clk);
    write_en = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    repeat (30) @(negedge clk);
    chk("drain_level", 64'(fifo_level), 64'(0));
    chk("drain_awvalid", 64'(awvalid), 64'(0));

`ifdef AXIL_WR_TIMEOUT_EN
    bvalid = 1'b0;
    n_done = 0;
    push(32'h500, 32'h9, 4'hF);
    idle_in();
    repeat (TO + 4) @(negedge clk);
    chk("timeout_done_cnt", 64'(n_done), 64'(1));
    chk("timeout_resp", 64'(write_resp), 64'(2));
`endif

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/axil_write_master.md
Name: axil_write_master

Overview:
Parametrised AXI4-Lite write master. It accepts simple user write requests (write_en, write_addr_in, write_data_in, strobe_in) into a request FIFO and issues each one on the AW/W channels. It then collects the B response and reports completion through write_done and write_resp. It sits between the test/user write port and the AXI4-Lite interconnect, and adds FIFO backpressure, independent AW/W handshakes and response reporting.

Parameters:
WIDTH_ADDR, 32, address width of user port and AWADDR
WIDTH_DATA, 32, data width; must be 32 or 64; strobe width is WIDTH_DATA/8
FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2
TIMEOUT_CYCLES, 256, B-response timeout; used only with the optional feature

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
write_en  input  1  request strobe; accepted when write_ready=1
write_addr_in  input  WIDTH_ADDR  request address
write_data_in  input  WIDTH_DATA  request data
strobe_in  input  WIDTH_DATA/8  request byte strobes
write_ready  output  1  FIFO not full
write_done  output  1  one-cycle pulse per completed write
write_resp  output  2  BRESP of the completed write; valid with write_done
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
awaddr  output  WIDTH_ADDR  AXI write address
awprot  output  3  constant 3'b000
awvalid  output  1  AXI address valid
awready  input  1  AXI address ready
wdata  output  WIDTH_DATA  AXI write data
wstrb  output  WIDTH_DATA/8  AXI write strobes
wvalid  output  1  AXI data valid
wready  input  1  AXI data ready
bresp  input  2  AXI write response
bvalid  input  1  AXI response valid
bready  output  1  AXI response ready

Behaviour:
- Reset (reset_n=0, async): FIFO flushed, fifo_level=0, write_ready=1, awvalid=wvalid=bready=0, write_done=0, write_resp=2'b00, awaddr/wdata/wstrb=0, FSM=IDLE.
- A reset mid-transaction drops the transaction; no write_done is generated for it.
- Push: on a rising edge where write_en=1 and write_ready=1, {addr,data,strb} are stored.
  - write_en while write_ready=0 is ignored; the request is dropped and no error is flagged.
- write_ready = (fifo_level != FIFO_DEPTH), derived from registered occupancy.
- A push and a pop on the same edge leave fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_RESP. Only one AXI transaction is outstanding at a time.
  - IDLE: if the FIFO is non-empty, pop the head into awaddr/wdata/wstrb, set awvalid=wvalid=1, go to ISSUE.
  - ISSUE: awvalid clears on the edge where awvalid&awready; wvalid clears on the edge where wvalid&wready.
    - The two handshakes complete in any order or on the same edge.
    - When both are done, set bready=1 and go to WAIT_RESP.
    - awaddr/wdata/wstrb stay stable while their valid is high.
  - WAIT_RESP: on the edge where bvalid&bready, write_done pulses for the following cycle, write_resp<=bresp, bready<=0.
    - If the FIFO is non-empty on that edge, pop the next entry and go directly to ISSUE (back-to-back).
    - Otherwise go to IDLE.
- Latency: with the FIFO empty and the FSM in IDLE, a request pushed at edge E0 has awvalid=wvalid=1 after E0+1.
  - With awready=wready=bvalid=1, write_done is high after E0+3.
- Strobes pass through unchanged; an all-zero strobe is still issued and completes normally.
- Any bresp value, including SLVERR (2'b10) and DECERR (2'b11), is reported and counts as completion.
- The FIFO is never popped while a transaction is in ISSUE or WAIT_RESP except on the B handshake edge.

Optional Feature:
- Macro AXIL_WR_TIMEOUT_EN.
- Defined:
  - A counter starts when the FSM enters WAIT_RESP.
  - If bvalid is not seen within TIMEOUT_CYCLES cycles, the FSM forces completion: write_done pulses with write_resp=2'b10, bready drops, and the FSM proceeds as on a normal B handshake.
  - A bvalid arriving in the same cycle the count expires takes priority; its real bresp is reported.
- Undefined: no counter; WAIT_RESP waits for bvalid indefinitely.

Test Plan:
- Single write:
  - Stimulus: addr=0x0000_0010, data=0xDEAD_BEEF, strb=4'hF; awready=wready=1, bvalid one cycle after bready with bresp=0.
  - Required: awaddr=0x10 and wdata=0xDEADBEEF with valids high for exactly 1 cycle; one write_done pulse with write_resp=0.
- FIFO fill:
  - Stimulus: hold awready=0 and push 5 writes (FIFO_DEPTH=4).
  - Required: the first write is popped to AXI; the next 4 fill the FIFO (fifo_level=4, write_ready=0); any 6th write is dropped. Release awready: exactly 5 write_done pulses, addresses in push order.
- Skewed handshakes:
  - Stimulus: wready high 3 cycles before awready.
  - Required: wvalid drops first, awvalid holds, bready rises only after both handshakes complete.
- Error response:
  - Stimulus: bresp=2'b11.
  - Required: write_done with write_resp=2'b11; the next queued write is issued back-to-back.
- Reset mid-transaction:
  - Stimulus: reset_n=0 while in WAIT_RESP with 2 entries queued.
  - Required: all outputs take their reset values immediately, fifo_level=0, no write_done after reset release.
- Timeout (AXIL_WR_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: never assert bvalid.
  - Required: write_done with write_resp=2'b10 after 16 cycles in WAIT_RESP.
